jpeg_spi_streamer: RTL and testbench
====================================

# jpeg_spi_streamer

Read-side sequencer between the JPEG encoder and the ESP32 SPI slave. After a completed encode it serves a complete JPEG file one byte per SPI read request, in this order:

- the header bytes, fetched from the encoder's header ROM;
- `jpeg_size` compressed bytes, fetched from the shared frame buffer;
- the EOI marker `FF D9`.

It runs entirely in the `pclk` domain and presents a prefetched byte to the SPI slave.

## Interface
Parameters:
- `HDR_LEN`, default 623: header ROM length in bytes (10-bit address space).
- `DATA_BASE`, default 0: frame-buffer address of the first compressed byte.

Ports:
- `pclk`  in  1  system clock. All logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `je_done`  in  1  one-cycle pulse at the end of an encode; arms a new transfer.
- `jpeg_size`  in  17  compressed byte count; sampled on `je_done`.
- `hd_addr`  out  10  header ROM address.
- `hd_data`  in  8  header ROM data; valid 1 cycle after `hd_addr`.
- `je_addr`  out  17  frame-buffer read address.
- `je_data`  in  8  frame-buffer data; valid 1 cycle after `je_addr`.
- `spi_rd`  in  1  one-cycle pulse: current byte consumed, advance to the next.
- `spi_data`  out  8  byte currently offered to the SPI slave.

## Operation
States: IDLE, HDR, DATA, EOI0, EOI1, DONE.

- **Reset values:** state IDLE, `hd_addr` 0, `je_addr` `DATA_BASE`, `spi_data` 0x00, size register 0.
- **`je_done` (any state):**
  - Latch `jpeg_size` into the size register and zero the byte index.
  - Set `hd_addr` to 0 and go to HDR.
  - Prefetch header byte 0 into `spi_data`.
  - A `je_done` that arrives mid-transfer restarts the transfer cleanly; the previous transfer is abandoned.
- **HDR:**
  - Each `spi_rd` increments `hd_addr`.
  - After byte `HDR_LEN-1` is consumed, go to DATA with `je_addr` = `DATA_BASE`.
  - If the latched size is 0, go to EOI0 instead.
- **DATA:**
  - Each `spi_rd` increments `je_addr`. The address is 17-bit and never wraps inside a frame.
  - After byte `size-1` is consumed, go to EOI0.
- **EOI0:** offer 0xFF. On `spi_rd`, go to EOI1.
- **EOI1:** offer 0xD9. On `spi_rd`, go to DONE.
- **DONE:** offer 0x00. Further `spi_rd` pulses are ignored. Stay in DONE until the next `je_done`.
- **IDLE:** `spi_rd` is ignored and `spi_data` holds 0x00.
- **Address routing:** `je_addr` is driven only with the frame-buffer pointer. The top level multiplexes this block against the other reader of the buffer.
- **Counter widths:** header index 10 bits, data index 17 bits. Comparisons are against `HDR_LEN-1` and `size-1`, with the size-0 case handled explicitly as above.

## Timing
- **Prefetch latency:** after `je_done` or `spi_rd` at edge N, the new address is registered at N+1 and `spi_data` holds the new byte from edge N+2.
- **Request spacing:** `spi_rd` pulses are at least 3 `pclk` cycles apart. Pulses spaced closer than that are undefined behaviour.
- **`spi_data` stability:** it is registered and stable between updates.
- **Simultaneous events:** if `je_done` and `spi_rd` occur in the same cycle, `je_done` wins.
- **Reset:** asserting `reset_n` low at any point returns the block to IDLE immediately, with all outputs at their reset values.

## Configuration
Macro `JPEG_SPI_SIZE_PREFIX_EN`.
- **Defined:** before the header, emit a 4-byte little-endian total file length: `HDR_LEN + size + 2`, 32-bit, upper bits zero. Each prefix byte is consumed by one `spi_rd`. This adds state PFX (4 bytes) between `je_done` and HDR.
- **Undefined:** the stream starts directly with header byte 0, and no PFX state exists.

## Structure
- **Shared package `jpeg_spi_pkg`:**
  - state enum;
  - `EOI_HI` = 8'hFF, `EOI_LO` = 8'hD9, `IDLE_BYTE` = 8'h00;
  - default `HDR_LEN`.
- **Sub-module `jpeg_spi_fetch`:** the source mux plus the one-cycle-latency capture register producing `spi_data`. The state and counters stay in the top module.

## Test plan
- **Basic stream:** `HDR_LEN`=4, ROM = 11 22 33 44, `jpeg_size`=3, buffer = AA BB CC. Pulse `je_done`, then 9 `spi_rd` spaced 4 cycles apart. Bytes read: 11 22 33 44 AA BB CC FF D9, then 00.
- **Zero size:** `jpeg_size`=0. Stream is the header followed directly by FF D9. `je_addr` never advances.
- **Mid-transfer restart:** `je_done` in DATA after 2 data bytes. The next byte is header byte 0, and the new `jpeg_size` is latched.
- **Reset mid-transfer:** `reset_n` low in HDR. `spi_data`=00 and `hd_addr`=0 immediately. `spi_rd` after release has no effect.
- **Collision:** `je_done` and `spi_rd` in the same cycle. The first offered byte is header byte 0.
- **Size prefix:** with `JPEG_SPI_SIZE_PREFIX_EN` defined, `HDR_LEN`=4, `jpeg_size`=3. First 4 bytes are 09 00 00 00, then the header.

Source files
------------

// File: rtl/jpeg_spi_pkg.sv
// Shared constants for the JPEG-over-SPI read sequencer.
// Optional macro JPEG_SPI_SIZE_PREFIX_EN adds the PFX state (4-byte file length).
package jpeg_spi_pkg;

    localparam int HDR_LEN_DEFAULT = 623;

    localparam logic [7:0] EOI_HI    = 8'hFF;
    localparam logic [7:0] EOI_LO    = 8'hD9;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    // State encoding, kept as plain constants for compatibility with older tools.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EOI0 = 3'd3;
    localparam logic [2:0] ST_EOI1 = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
`ifdef JPEG_SPI_SIZE_PREFIX_EN
    localparam logic [2:0] ST_PFX  = 3'd6;
`endif

endpackage

// File: rtl/jpeg_spi_fetch.sv
// Byte source mux and capture register feeding the SPI slave.
// The addresses driven by the top are one cycle old when this register
// samples, so the captured byte always matches the current state.
// Optional macro JPEG_SPI_SIZE_PREFIX_EN adds the prefix-byte source.
module jpeg_spi_fetch
    import jpeg_spi_pkg::*;
(
    input  logic       pclk,
    input  logic       reset_n,
    input  logic [2:0] state,
    input  logic [7:0] hd_data,
    input  logic [7:0] je_data,
`ifdef JPEG_SPI_SIZE_PREFIX_EN
    input  logic [7:0] pfx_byte,
`endif
    output logic [7:0] spi_data
);

    logic [7:0] spi_data_d;
    logic [7:0] spi_data_q;

    // Select the byte that belongs to the current state.
    always_comb begin
        // NOTE: default first so every path assigns spi_data_d and no latch is inferred.
        spi_data_d = IDLE_BYTE;
        case (state)
`ifdef JPEG_SPI_SIZE_PREFIX_EN
            ST_PFX:  spi_data_d = pfx_byte;
`endif
            ST_HDR:  spi_data_d = hd_data;
            ST_DATA: spi_data_d = je_data;
            ST_EOI0: spi_data_d = EOI_HI;
            ST_EOI1: spi_data_d = EOI_LO;
            default: spi_data_d = IDLE_BYTE;
        endcase
    end

    // Capture register; cleared asynchronously so the output drops at once on reset.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            spi_data_q <= IDLE_BYTE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            spi_data_q <= spi_data_d;
        end
    end

    assign spi_data = spi_data_q;

endmodule

// File: rtl/jpeg_spi_streamer.sv
// Read-side sequencer: serves header ROM bytes, jpeg_size frame-buffer bytes
// and the FF D9 trailer, one byte per spi_rd pulse.
// Events are registered once (done_q / rd_q) so addresses move one edge after
// the request and the fetched byte appears one edge after that.
// Optional macro JPEG_SPI_SIZE_PREFIX_EN prepends a 4-byte little-endian
// total file length (HDR_LEN + size + 2).
module jpeg_spi_streamer
    import jpeg_spi_pkg::*;
#(
    parameter int HDR_LEN   = HDR_LEN_DEFAULT,
    parameter int DATA_BASE = 0
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        je_done,
    input  logic [16:0] jpeg_size,
    output logic [9:0]  hd_addr,
    input  logic [7:0]  hd_data,
    output logic [16:0] je_addr,
    input  logic [7:0]  je_data,
    input  logic        spi_rd,
    output logic [7:0]  spi_data
);

    localparam logic [9:0]  HDR_LAST  = 10'(HDR_LEN - 1);
    localparam logic [16:0] BASE_ADDR = 17'(DATA_BASE);

    logic [2:0]  state_d,    state_q;
    logic [9:0]  hd_addr_d,  hd_addr_q;
    logic [16:0] je_addr_d,  je_addr_q;
    logic [16:0] data_idx_d, data_idx_q;
    logic [16:0] size_d,     size_q;
    logic        done_d,     done_q;
    logic        rd_d,       rd_q;
`ifdef JPEG_SPI_SIZE_PREFIX_EN
    logic [1:0]  pfx_idx_d,  pfx_idx_q;
    logic [31:0] file_len;
    logic [7:0]  pfx_byte;

    // Total file length and the prefix byte currently offered.
    always_comb begin
        file_len = 32'(HDR_LEN) + {15'd0, size_q} + 32'd2;
        pfx_byte = file_len[{pfx_idx_q, 3'b000} +: 8];
    end
`endif

    // Next-state logic: a registered je_done restarts; otherwise a registered spi_rd advances.
    always_comb begin
        state_d    = state_q;
        hd_addr_d  = hd_addr_q;
        je_addr_d  = je_addr_q;
        data_idx_d = data_idx_q;
        size_d     = je_done ? jpeg_size : size_q;
        done_d     = je_done;
        rd_d       = spi_rd & ~je_done;   // je_done wins a collision
`ifdef JPEG_SPI_SIZE_PREFIX_EN
        pfx_idx_d  = pfx_idx_q;
`endif
        if (done_q) begin
            hd_addr_d  = '0;
            je_addr_d  = BASE_ADDR;
            data_idx_d = '0;
`ifdef JPEG_SPI_SIZE_PREFIX_EN
            pfx_idx_d  = '0;
            state_d    = ST_PFX;
`else
            state_d    = ST_HDR;
`endif
        end else if (rd_q) begin
            case (state_q)
`ifdef JPEG_SPI_SIZE_PREFIX_EN
                ST_PFX: begin
                    if (pfx_idx_q == 2'd3) begin
                        state_d   = ST_HDR;
                        hd_addr_d = '0;
                    end else begin
                        pfx_idx_d = pfx_idx_q + 2'd1;
                    end
                end
`endif
                ST_HDR: begin
                    if (hd_addr_q == HDR_LAST) begin
                        je_addr_d  = BASE_ADDR;
                        data_idx_d = '0;
                        state_d    = (size_q == '0) ? ST_EOI0 : ST_DATA;
                    end else begin
                        hd_addr_d = hd_addr_q + 10'd1;
                    end
                end
                ST_DATA: begin
                    if (data_idx_q == size_q - 17'd1) begin
                        state_d = ST_EOI0;
                    end else begin
                        data_idx_d = data_idx_q + 17'd1;
                        je_addr_d  = je_addr_q + 17'd1;
                    end
                end
                ST_EOI0: state_d = ST_EOI1;
                ST_EOI1: state_d = ST_DONE;
                default: state_d = state_q;   // IDLE and DONE ignore reads
            endcase
        end
    end

    // State, counters and address registers.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            hd_addr_q  <= '0;
            je_addr_q  <= BASE_ADDR;
            data_idx_q <= '0;
            size_q     <= '0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
`ifdef JPEG_SPI_SIZE_PREFIX_EN
            pfx_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hd_addr_q  <= hd_addr_d;
            je_addr_q  <= je_addr_d;
            data_idx_q <= data_idx_d;
            size_q     <= size_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
`ifdef JPEG_SPI_SIZE_PREFIX_EN
            pfx_idx_q  <= pfx_idx_d;
`endif
        end
    end

    assign hd_addr = hd_addr_q;
    assign je_addr = je_addr_q;

    jpeg_spi_fetch u_fetch (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .state    (state_q),
        .hd_data  (hd_data),
        .je_data  (je_data),
`ifdef JPEG_SPI_SIZE_PREFIX_EN
        .pfx_byte (pfx_byte),
`endif
        .spi_data (spi_data)
    );

endmodule

// File: tb/tb_jpeg_spi_streamer.sv
// Self-checking bench for jpeg_spi_streamer. The reference model is a queue of
// the bytes a complete JPEG file must contain; each spi_rd pops one byte.
// Honours JPEG_SPI_SIZE_PREFIX_EN the same way as the design.
module tb_jpeg_spi_streamer;

    localparam int          HDR_LEN   = 4;
    localparam int          DATA_BASE = 16;
    localparam logic [16:0] BASE      = 17'(DATA_BASE);

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        je_done = 1'b0;
    logic [16:0] jpeg_size = '0;
    logic [9:0]  hd_addr;
    logic [7:0]  hd_data;
    logic [16:0] je_addr;
    logic [7:0]  je_data;
    logic        spi_rd = 1'b0;
    logic [7:0]  spi_data;

    logic [7:0] rom [1024];
    logic [7:0] fb_mem [131072];
    logic [7:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    // Memories answer within the cycle after their address changes.
    assign hd_data = rom[hd_addr];
    assign je_data = fb_mem[je_addr];

    jpeg_spi_streamer #(.HDR_LEN(HDR_LEN), .DATA_BASE(DATA_BASE)) dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .je_done   (je_done),
        .jpeg_size (jpeg_size),
        .hd_addr   (hd_addr),
        .hd_data   (hd_data),
        .je_addr   (je_addr),
        .je_data   (je_data),
        .spi_rd    (spi_rd),
        .spi_data  (spi_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] head_byte();
        return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    endfunction

    // Expected file contents for a transfer of sz compressed bytes.
    task automatic build_model(input int sz);
        logic [31:0] total;
        exp_q.delete();
        total = 32'(HDR_LEN + sz + 2);
`ifdef JPEG_SPI_SIZE_PREFIX_EN
        for (int b = 0; b < 4; b++) exp_q.push_back(total[8*b +: 8]);
`else
        if (total == 32'd0) exp_q.push_back(8'h00);   // never taken
`endif
        for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(rom[i]);
        for (int i = 0; i < sz; i++) exp_q.push_back(fb_mem[DATA_BASE + i]);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
    endtask

    // Pulse je_done (optionally together with spi_rd) and check the first byte.
    task automatic start(input string tag, input int sz, input logic with_rd);
        @(negedge pclk);
        jpeg_size = 17'(sz);
        je_done   = 1'b1;
        spi_rd    = with_rd;
        build_model(sz);
        @(negedge pclk);
        je_done   = 1'b0;
        spi_rd    = 1'b0;
        jpeg_size = 17'($urandom);   // must not matter after the sampling edge
        @(negedge pclk);
        @(negedge pclk);
        check($sformatf("%s_first", tag), {24'd0, spi_data}, {24'd0, head_byte()});
        check($sformatf("%s_hd0", tag), {22'd0, hd_addr}, 32'd0);
    endtask

    // Consume one byte: offered byte, hold one cycle after the pulse, new byte after two.
    task automatic read_step(input string tag);
        logic [7:0] cur;
        cur = head_byte();
        check($sformatf("%s_cur", tag), {24'd0, spi_data}, {24'd0, cur});
        @(negedge pclk);
        spi_rd = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge pclk);
        spi_rd = 1'b0;
        @(negedge pclk);
        check($sformatf("%s_hold", tag), {24'd0, spi_data}, {24'd0, cur});
        @(negedge pclk);
        check($sformatf("%s_next", tag), {24'd0, spi_data}, {24'd0, head_byte()});
    endtask

    initial begin
        int n;
        int sz;
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        for (int i = 0; i < 131072; i++) fb_mem[i] = 8'h00;
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        fb_mem[DATA_BASE] = 8'hAA; fb_mem[DATA_BASE+1] = 8'hBB; fb_mem[DATA_BASE+2] = 8'hCC;

        // Reset values
        repeat (3) @(negedge pclk);
        check("rst_spi", {24'd0, spi_data}, 32'd0);
        check("rst_hd", {22'd0, hd_addr}, 32'd0);
        check("rst_je", {15'd0, je_addr}, {15'd0, BASE});
        reset_n = 1'b1;
        @(negedge pclk);
        read_step("idle_rd");

        // Basic stream: 11 22 33 44 AA BB CC FF D9 then 00
        start("basic", 3, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n + 1; i++) read_step($sformatf("basic%0d", i));

        // Zero size: header then FF D9, frame-buffer pointer stays put
        start("zero", 0, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            read_step($sformatf("zero%0d", i));
            check($sformatf("zero_je%0d", i), {15'd0, je_addr}, {15'd0, BASE});
        end

        // Collision: je_done and spi_rd together, header byte 0 offered first
        start("coll", 2, 1'b1);
        read_step("coll_rd");

        // Mid-transfer restart after two data bytes, with a new size
        for (int i = 0; i < 8; i++) fb_mem[DATA_BASE + i] = 8'($urandom);
        start("mid_a", 6, 1'b0);
        n = exp_q.size() - 6 - 2 + 2;   // prefix + header + two data bytes
        for (int i = 0; i < n; i++) read_step($sformatf("mid_a%0d", i));
        check("mid_je", {15'd0, je_addr}, {15'd0, BASE + 17'd2});
        start("mid_b", 5, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n + 1; i++) read_step($sformatf("mid_b%0d", i));

        // Reset while in the header
        start("rst", 3, 1'b0);
        n = exp_q.size() - HDR_LEN - 3 - 2 + 2;   // into the header by two bytes
        for (int i = 0; i < n; i++) read_step($sformatf("rst_pre%0d", i));
        @(negedge pclk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_spi", {24'd0, spi_data}, 32'd0);
        check("rst_mid_hd", {22'd0, hd_addr}, 32'd0);
        exp_q.delete();
        @(negedge pclk);
        reset_n = 1'b1;
        read_step("rst_post");

        // Randomized frames against the queue model
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < HDR_LEN; i++) rom[i] = 8'($urandom);
            sz = int'($urandom_range(0, 24));
            for (int i = 0; i < sz; i++) fb_mem[DATA_BASE + i] = 8'($urandom);
            start($sformatf("rnd%0d", f), sz, 1'($urandom_range(0, 1)));
            n = exp_q.size();
            for (int i = 0; i < n + 1; i++) read_step($sformatf("rnd%0d_%0d", f, i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
